// File: rtl/drum_voice_mixer.sv
// rtl/drum_voice_mixer.sv - sequential gain/mute MAC mixing NUM_CH voices into one saturated sample per frame
module drum_voice_mixer #(
  parameter int NUM_CH    = 4,
  parameter int GAIN_BITS = 8
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic                        pblrc,
  input  logic signed [15:0]          ch_sample [NUM_CH],
  input  logic        [GAIN_BITS-1:0] ch_gain   [NUM_CH],
  input  logic        [NUM_CH-1:0]    ch_mute,
  output logic signed [15:0]          mix_out,
  output logic                        mix_valid,
  output logic                        clip,
  output logic                        overrun
);

  localparam int PROD_W = 17 + GAIN_BITS;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH) + 1;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SHIFT  = GAIN_BITS - 1;

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t state, state_next;

  logic                       pblrc_q;
  logic                       start;
  logic                       last;
  logic [IDX_W-1:0]           idx;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    r;
  logic signed [PROD_W-1:0]   samp_ext;
  logic signed [PROD_W-1:0]   gain_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    term;
  logic                       sat_hi;
  logic                       sat_lo;
  logic signed [15:0]         sat_val;
  logic                       clip_q;

  logic signed [15:0]         snap_sample [NUM_CH];
  logic [GAIN_BITS-1:0]       snap_gain   [NUM_CH];
  logic [NUM_CH-1:0]          snap_mute;

  // Frame clock is plain data; a rising edge requests one mix.
  always_ff @(posedge mclk) begin
    if (rst) pblrc_q <= 1'b0;
    else     pblrc_q <= pblrc;
  end

  assign start = pblrc & ~pblrc_q;
  assign last  = (idx == IDX_W'(NUM_CH - 1));

  // State register.
  always_ff @(posedge mclk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> ACC (NUM_CH cycles) -> SAT (result visible) -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACC;
      ACC:     if (last)  state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shared multiplier: current channel product, accumulation and saturation of the running sum.
  // Saturation is evaluated on acc_next so the final result is registered entering SAT.
  always_comb begin
    samp_ext = $signed({{(PROD_W-16){snap_sample[idx][15]}}, snap_sample[idx]});
    gain_ext = $signed({{(PROD_W-GAIN_BITS){1'b0}}, snap_gain[idx]});
    prod     = samp_ext * gain_ext;
    term     = snap_mute[idx] ? '0 : $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    acc_next = acc + term;
    r        = acc_next >>> SHIFT;
    sat_hi   = ~r[ACC_W-1] &  (|r[ACC_W-2:15]);
    sat_lo   =  r[ACC_W-1] & ~(&r[ACC_W-2:15]);
    if (sat_hi)      sat_val = 16'sh7FFF;
    else if (sat_lo) sat_val = -16'sh8000;
    else             sat_val = r[15:0];
  end

  // Snapshot, accumulator, held result and sticky overrun flag.
  always_ff @(posedge mclk) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      mix_out   <= '0;
      clip_q    <= 1'b0;
      overrun   <= 1'b0;
      snap_mute <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_sample[i] <= '0;
        snap_gain[i]   <= '0;
      end
    end else begin
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            idx       <= '0;
            snap_mute <= ch_mute;
            for (int i = 0; i < NUM_CH; i++) begin
              snap_sample[i] <= ch_sample[i];
              snap_gain[i]   <= ch_gain[i];
            end
          end
        end
        ACC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (last) begin
            mix_out <= sat_val;
            clip_q  <= sat_hi | sat_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Output strobes are only asserted during the SAT cycle.
  always_comb begin
    mix_valid = (state == SAT);
    clip      = (state == SAT) & clip_q;
  end

endmodule

// File: tb/tb_drum_voice_mixer.sv
// tb/tb_drum_voice_mixer.sv - scoreboard bench with randomized frames against an arithmetic mix model
module tb_drum_voice_mixer;
  localparam int NUM_CH    = 4;
  localparam int GAIN_BITS = 8;

  typedef struct {
    int mix;
    bit clp;
    int cyc;
  } exp_t;

  logic                       mclk = 1'b0;
  logic                       rst  = 1'b1;
  logic                       pblrc = 1'b0;
  logic signed [15:0]         ch_sample [NUM_CH];
  logic        [GAIN_BITS-1:0] ch_gain  [NUM_CH];
  logic        [NUM_CH-1:0]   ch_mute;
  logic signed [15:0]         mix_out;
  logic                       mix_valid;
  logic                       clip;
  logic                       overrun;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   exp_overrun = 1'b0;
  exp_t sb [$];

  drum_voice_mixer #(.NUM_CH(NUM_CH), .GAIN_BITS(GAIN_BITS)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .pblrc     (pblrc),
    .ch_sample (ch_sample),
    .ch_gain   (ch_gain),
    .ch_mute   (ch_mute),
    .mix_out   (mix_out),
    .mix_valid (mix_valid),
    .clip      (clip),
    .overrun   (overrun)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: sum of unmuted sample*gain, floor-divided by unity gain, clamped to 16 bits.
  function automatic exp_t model();
    exp_t   e;
    longint acc = 0;
    longint q;
    for (int i = 0; i < NUM_CH; i++)
      if (!ch_mute[i]) acc += longint'(ch_sample[i]) * longint'(ch_gain[i]);
    q = acc / (longint'(1) << (GAIN_BITS - 1));
    if (q * (longint'(1) << (GAIN_BITS - 1)) != acc && acc < 0) q -= 1;
    e.clp = 1'b0;
    if (q > 32767)       begin e.mix = 32767;  e.clp = 1'b1; end
    else if (q < -32768) begin e.mix = -32768; e.clp = 1'b1; end
    else                 e.mix = int'(q);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge mclk) begin
    if (!rst) begin
      if (mix_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid mix_out=%0d required=no valid", mix_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("mix_out", mix_out, e.mix);
          chk("clip", clip, e.clp);
          chk("latency_cycle", cyc, e.cyc);
        end
        chk("overrun", overrun, exp_overrun);
      end else begin
        chk("clip_without_valid", clip, 0);
      end
    end
  end

  // Issue one frame edge with the currently driven inputs; optionally scramble inputs after the snapshot.
  task automatic fire(input bit scramble);
    exp_t e;
    @(posedge mclk); #1;
    pblrc = 1'b1;
    e = model();
    e.cyc = cyc + 1 + NUM_CH;
    sb.push_back(e);
    @(posedge mclk); #1;
    pblrc = 1'b0;
    if (scramble) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_sample[i] = 16'($urandom);
        ch_gain[i]   = GAIN_BITS'($urandom);
      end
      ch_mute = NUM_CH'($urandom);
    end
    repeat (NUM_CH + 3) @(posedge mclk);
    #1;
  endtask

  task automatic set_all(input int s, input int g, input logic [NUM_CH-1:0] m);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sample[i] = 16'(s);
      ch_gain[i]   = GAIN_BITS'(g);
    end
    ch_mute = m;
  endtask

  initial begin
    int w;
    set_all(0, 0, '0);
    repeat (3) @(posedge mclk);
    #1 rst = 1'b0;
    chk("reset_mix_out", mix_out, 0);
    chk("reset_mix_valid", mix_valid, 0);
    chk("reset_clip", clip, 0);
    chk("reset_overrun", overrun, 0);

    // Basic unity sum.
    set_all(0, 128, '0);
    ch_sample[0] = 1000; ch_sample[1] = 2000; ch_sample[2] = -500; ch_sample[3] = 0;
    fire(1'b0);

    // Positive and negative saturation.
    set_all(30000, 255, '0);
    fire(1'b0);
    set_all(-30000, 255, '0);
    fire(1'b0);

    // Floor rounding of half-gain odd samples.
    set_all(0, 64, 4'b1110);
    ch_sample[0] = 3;
    fire(1'b0);
    ch_sample[0] = -3;
    fire(1'b0);

    // Mute and input changes after the snapshot.
    set_all(100, 128, 4'b0001);
    ch_sample[0] = 20000;
    fire(1'b1);

    // Randomized frames, some with post-snapshot scrambling.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_sample[i] = ($urandom_range(0, 3) == 0) ? ((($urandom & 1) != 0) ? 16'sh7FFF : -16'sh8000)
                                                    : 16'($urandom);
        ch_gain[i]   = GAIN_BITS'($urandom);
      end
      ch_mute = NUM_CH'($urandom);
      fire(n[0]);
    end

    // Second frame edge two cycles after the first: dropped, overrun latches.
    set_all(1234, 100, '0);
    @(posedge mclk); #1;
    pblrc = 1'b1;
    begin
      exp_t e;
      e = model();
      e.cyc = cyc + 1 + NUM_CH;
      sb.push_back(e);
    end
    @(posedge mclk); #1 pblrc = 1'b0;
    @(posedge mclk); #1 pblrc = 1'b1; exp_overrun = 1'b1;
    @(posedge mclk); #1 pblrc = 1'b0;
    repeat (NUM_CH + 4) @(posedge mclk);
    #1;
    chk("overrun_set", overrun, 1);
    set_all(-700, 200, 4'b0100);
    fire(1'b0);
    chk("overrun_sticky", overrun, 1);

    // Reset during the second ACC cycle aborts the mix.
    set_all(5000, 128, '0);
    @(posedge mclk); #1 pblrc = 1'b1;
    @(posedge mclk); #1 pblrc = 1'b0;
    @(posedge mclk); #1 rst = 1'b1;
    @(posedge mclk); #1 rst = 1'b0;
    exp_overrun = 1'b0;
    chk("midreset_mix_out", mix_out, 0);
    chk("midreset_mix_valid", mix_valid, 0);
    chk("midreset_clip", clip, 0);
    chk("midreset_overrun", overrun, 0);
    repeat (NUM_CH + 4) @(posedge mclk);
    #1;
    set_all(-1000, 128, 4'b1000);
    fire(1'b0);

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge mclk);
      w++;
    end
    chk("pending_results", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
